// File: rtl/parametric_mux_arb.sv
// parametric_mux_arb: N-input to 1-output stream arbiter with a one-entry
// output buffer.
//
// Default build: round-robin grant. The search starts at ptr, and ptr moves
// past each winner.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority instead. The lowest asserted
// index wins, and no ptr register is built.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             async active-low reset
//   recv_val[i]         input i valid
//   recv_rdy[i]         input i ready; only the granted input is ever ready
//   flattened_recv_msg  input i at [(p_ninputs-1-i)*p_nbits +: p_nbits]
//                       (input 0 sits in the MSB slice)
//   send_val            output buffer full
//   send_rdy            downstream ready
//   send_msg            buffered message
//   send_sel            index of the input that sourced send_msg

// Per-input slice: ready gating and message gating for the AND-OR output mux.
module parametric_mux_arb_lane #(
  parameter int p_nbits = 8
) (
  input  logic               grant,
  input  logic               accept,
  input  logic               reset_n,
  input  logic [p_nbits-1:0] msg,
  output logic               rdy,
  output logic [p_nbits-1:0] msg_gated
);
  // The reset term keeps ready low for the whole reset window, not only
  // while state is clear.
  assign rdy       = grant & accept & reset_n;
  assign msg_gated = grant ? msg : '0;
endmodule

module parametric_mux_arb #(
  parameter int p_nbits   = 8,
  parameter int p_ninputs = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [p_ninputs-1:0]           recv_val,
  output logic [p_ninputs-1:0]           recv_rdy,
  input  logic [p_ninputs*p_nbits-1:0]   flattened_recv_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [p_nbits-1:0]             send_msg,
  output logic [$clog2(p_ninputs)-1:0]   send_sel
);
  localparam int SW = $clog2(p_ninputs);

  logic [p_ninputs-1:0][p_nbits-1:0] slice;
  logic [p_ninputs-1:0][p_nbits-1:0] gated;
  logic [p_ninputs-1:0]              grant;
  logic [SW-1:0]                     gidx;
  logic                              any;
  logic [SW:0]                       cand;
  logic [p_nbits-1:0]                mux_msg;
  logic                              full;
  logic                              accept;
  logic                              xfer_in;
  logic [SW-1:0]                     start;
  logic [p_nbits-1:0]                buf_msg;
  logic [SW-1:0]                     buf_sel;

  assign slice  = flattened_recv_msg;
  assign accept = ~full | send_rdy;

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [SW-1:0] ptr;
  assign start = ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (xfer_in)
      ptr <= (gidx == SW'(p_ninputs - 1)) ? '0 : gidx + SW'(1);
  end
`endif

  // Walk from start upward modulo p_ninputs. cand has one extra bit so
  // start+k never overflows before the wrap subtraction.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < p_ninputs; k++) begin
      cand = {1'b0, start} + (SW+1)'(k);
      if (cand >= (SW+1)'(p_ninputs))
        cand = cand - (SW+1)'(p_ninputs);
      if (!any && recv_val[cand[SW-1:0]]) begin
        any                = 1'b1;
        grant[cand[SW-1:0]] = 1'b1;
        gidx               = cand[SW-1:0];
      end
    end
  end

  for (genvar g = 0; g < p_ninputs; g++) begin : g_lane
    parametric_mux_arb_lane #(.p_nbits(p_nbits)) u_lane (
      .grant     (grant[g]),
      .accept    (accept),
      .reset_n   (reset_n),
      .msg       (slice[p_ninputs-1-g]),
      .rdy       (recv_rdy[g]),
      .msg_gated (gated[g])
    );
  end

  // Grant is one-hot, so OR-reducing the gated slices is the mux.
  always_comb begin
    mux_msg = '0;
    for (int i = 0; i < p_ninputs; i++)
      mux_msg = mux_msg | gated[i];
  end

  assign xfer_in = any & accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full    <= 1'b0;
      buf_msg <= '0;
      buf_sel <= '0;
    end else if (xfer_in) begin
      full    <= 1'b1;
      buf_msg <= mux_msg;
      buf_sel <= gidx;
    end else if (full && send_rdy) begin
      full    <= 1'b0;
    end
  end

  assign send_val = full;
  assign send_msg = buf_msg;
  assign send_sel = buf_sel;
endmodule

// File: tb/tb_parametric_mux_arb.sv
// Self-checking bench for parametric_mux_arb (p_nbits=8, p_ninputs=4).
//
// The reference model keeps the buffer state, the output-side full flag and
// ptr as plain variables. It picks the grant as the valid input with the
// smallest circular distance from ptr. A negedge compare process checks every
// output against the model each cycle. Directed scenarios add literal
// expectations on top of that.
module tb_parametric_mux_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = $clog2(N);

  logic             clk = 0;
  logic             reset_n = 0;
  logic [N-1:0]     recv_val = '0;
  logic [N-1:0]     recv_rdy;
  logic [N*W-1:0]   flat = '0;
  logic             send_val;
  logic             send_rdy = 0;
  logic [W-1:0]     send_msg;
  logic [SW-1:0]    send_sel;

  logic [W-1:0]     msgs [N];

  int checks = 0;
  int errors = 0;

  parametric_mux_arb #(.p_nbits(W), .p_ninputs(N)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .recv_val           (recv_val),
    .recv_rdy           (recv_rdy),
    .flattened_recv_msg (flat),
    .send_val           (send_val),
    .send_rdy           (send_rdy),
    .send_msg           (send_msg),
    .send_sel           (send_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr  = 0;
  bit          m_full = 0;
  logic [W-1:0] m_msg = '0;
  int          m_sel  = 0;

  function automatic int search_start();
`ifdef MUX_ARB_FIXED_PRIO_EN
    return 0;
`else
    return m_ptr;
`endif
  endfunction

  // Valid input closest (circularly, going upward) to the search start; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_full = 0; m_msg = '0; m_sel = 0;
    end else begin
      int g;
      g = pick(recv_val, search_start());
      if (g >= 0 && (!m_full || send_rdy)) begin
        m_full = 1;
        m_msg  = msgs[g];
        m_sel  = g;
`ifndef MUX_ARB_FIXED_PRIO_EN
        m_ptr  = (g + 1) % N;
`endif
      end else if (m_full && send_rdy) begin
        m_full = 0;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] exp_rdy;
      int g;
      exp_rdy = '0;
      g = pick(recv_val, search_start());
      if (reset_n && g >= 0 && (!m_full || send_rdy)) exp_rdy[g] = 1'b1;
      chk("cmp_recv_rdy", 32'(recv_rdy), 32'(exp_rdy));
      chk("cmp_send_val", 32'(send_val), 32'(m_full));
      chk("cmp_send_msg", 32'(send_msg), 32'(m_msg));
      chk("cmp_send_sel", 32'(send_sel), 32'(m_sel));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [N-1:0] v, input logic r);
    recv_val = v;
    send_rdy = r;
    for (int i = 0; i < N; i++) flat[(N-1-i)*W +: W] = msgs[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 0;
    drive('0, 0);
    #10;
    reset_n = 1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) msgs[i] = '0;
    drive('0, 0);
    #12;
    cmp_en = 1;
    chk("reset_send_val", 32'(send_val), 0);
    chk("reset_recv_rdy", 32'(recv_rdy), 0);
    chk("reset_send_msg", 32'(send_msg), 0);
    reset_n = 1;
    tick();

`ifndef MUX_ARB_FIXED_PRIO_EN
    // Single input 2.
    msgs[2] = 8'hA5;
    drive(4'b0100, 1);
    tick();
    chk("single_val", 32'(send_val), 1);
    chk("single_msg", 32'(send_msg), 32'hA5);
    chk("single_sel", 32'(send_sel), 2);
    chk("single_model_ptr", 32'(m_ptr), 3);
    drive('0, 1);
    tick();
    chk("single_drained", 32'(send_val), 0);

    // Round-robin fairness from ptr=0.
    do_reset();
    for (int i = 0; i < N; i++) msgs[i] = 8'h10 + 8'(i);
    drive(4'b1111, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_sel", 32'(send_sel), 32'(k % 4));
      chk("rr_msg", 32'(send_msg), 32'h10 + 32'(k % 4));
    end

    // Backpressure: buffer holds 0x10 from input 0, ptr=1.
    drive(4'b1111, 0);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_recv_rdy", 32'(recv_rdy), 0);
      chk("bp_msg", 32'(send_msg), 32'h10);
      chk("bp_val", 32'(send_val), 1);
      tick();
    end
    drive(4'b1111, 1);
    #1;
    chk("bp_release_rdy", 32'(recv_rdy), 32'b0010);
    tick();
    chk("bp_reload_sel", 32'(send_sel), 1);
    chk("bp_reload_msg", 32'(send_msg), 32'h11);

    // Wrap-around: steer ptr to 3, then 1001.
    do_reset();
    drive(4'b0100, 1);
    tick();
    drive(4'b1001, 1);
    tick();
    chk("wrap_sel3", 32'(send_sel), 3);
    tick();
    chk("wrap_sel0", 32'(send_sel), 0);
`endif

    // Reset mid-operation.
    do_reset();
    msgs[0] = 8'h7E;
    drive(4'b0001, 0);
    tick();
    chk("mid_loaded_msg", 32'(send_msg), 32'h7E);
    drive('0, 0);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_val", 32'(send_val), 0);
    chk("mid_rst_msg", 32'(send_msg), 0);
    chk("mid_rst_sel", 32'(send_sel), 0);
    chk("mid_rst_rdy", 32'(recv_rdy), 0);
    #1 reset_n = 1;
    drive(4'b0110, 1);
    tick();
    chk("mid_after_sel", 32'(send_sel), 1);

`ifdef MUX_ARB_FIXED_PRIO_EN
    do_reset();
    drive(4'b1111, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fixed_sel0", 32'(send_sel), 0);
    end
`endif

    // Randomized phase with occasional reset pulses.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) msgs[i] = 8'($urandom);
      drive(N'($urandom), ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 199) == 0) begin
        #1 reset_n = 0;
        #1 reset_n = 1;
      end
      tick();
    end

    drive('0, 1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/parametric_mux_arb.md
PARAMETRIC_MUX_ARB -- requirements
Module: parametric_mux_arb

Interface
REQ-001 SHALL have parameter p_nbits, default 8: message width in bits.
REQ-002 SHALL have parameter p_ninputs, default 4: number of input streams; at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port recv_val, input, p_ninputs bits: per-input valid; bit i belongs to input i.
REQ-006 SHALL have port recv_rdy, output, p_ninputs bits: per-input ready; bit i belongs to input i.
REQ-007 SHALL have port flattened_recv_msg, input, p_ninputs*p_nbits bits: input i message at bits [(p_ninputs-1-i)*p_nbits +: p_nbits], so input 0 occupies the MSB slice (same packing as the routing demux output).
REQ-008 SHALL have port send_val, output, 1 bit: output valid.
REQ-009 SHALL have port send_rdy, input, 1 bit: downstream ready.
REQ-010 SHALL have port send_msg, output, p_nbits bits: buffered message.
REQ-011 SHALL have port send_sel, output, $clog2(p_ninputs) bits: index of the input that sourced send_msg.

Function
REQ-012 SHALL contain a one-entry output buffer (msg, sel, full flag); send_val equals the full flag, and send_msg/send_sel are driven from the buffer.
REQ-013 SHALL treat a transfer as occurring on any edge where val and rdy are both 1; this applies to each input and to the output.
REQ-014 SHALL define accept = !full | send_rdy, so the buffer can load on the same cycle it drains.
REQ-015 SHALL grant at most one input per cycle: the first i with recv_val[i]=1, searching from ptr upward modulo p_ninputs.
REQ-016 SHALL drive recv_rdy[i] = grant[i] & accept; recv_rdy SHALL be zero for every non-granted input and SHALL NOT depend on recv_rdy itself.
REQ-017 On an input transfer from i, SHALL load the buffer with input i's message and sel=i, set full=1, and set ptr to (i+1) mod p_ninputs, wrapping from p_ninputs-1 to 0.
REQ-018 When the output transfers and no input transfers in the same cycle, SHALL clear full; ptr SHALL remain unchanged.
REQ-019 SHALL hold send_msg and send_sel stable while send_val=1 and send_rdy=0.
REQ-020 SHALL have a latency of exactly 1 cycle from input transfer to send_val=1; with send_rdy held at 1, throughput SHALL be one message per cycle.
REQ-021 With no recv_val asserted, SHALL NOT change ptr and SHALL NOT load the buffer.

Reset
REQ-022 While reset_n=0, SHALL asynchronously force full=0, ptr=0, send_val=0, send_msg=0, and send_sel=0.
REQ-023 While reset_n=0, SHALL force recv_rdy to all zeros.
REQ-024 An assertion of reset mid-transfer SHALL discard the buffered message, with no partial output.
REQ-025 After reset_n is released, the first grant SHALL be evaluated from ptr=0.

Configuration
REQ-026 With macro MUX_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority: the search always starts at 0, so the lowest asserted index wins, and ptr is neither implemented nor updated.
REQ-027 Without MUX_ARB_FIXED_PRIO_EN, SHALL use the round-robin arbitration of REQ-015 and REQ-017.

Verification (p_nbits=8, p_ninputs=4)
REQ-028 Single input: recv_val=0100, input 2 msg=0xA5, send_rdy=1 -> next cycle send_val=1, send_msg=0xA5, send_sel=2; ptr=3.
REQ-029 Round-robin fairness: all inputs valid continuously (msgs 0x10,0x11,0x12,0x13), send_rdy=1 -> send_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-030 Backpressure: buffer full, send_rdy=0 for 3 cycles, recv_val=1111 -> recv_rdy=0000 and send_msg stable for those 3 cycles; send_rdy=1 -> drain and reload in the same cycle.
REQ-031 Wrap-around: ptr=3, recv_val=1001 -> input 3 granted, then ptr=0 -> input 0 granted next.
REQ-032 Reset mid-operation: full=1 with send_msg=0x7E, reset_n pulsed low between edges -> send_val=0 immediately, ptr=0; after release, recv_val=0110 -> send_sel=1.
REQ-033 With MUX_ARB_FIXED_PRIO_EN defined: recv_val=1111 held, send_rdy=1 -> send_sel=0 every cycle.
